// File: rtl/prog_sequencer.sv
// Programmable control sequencer: fetches 16-bit instruction words from a synchronous
// program ROM and decodes them into register-file/ALU datapath controls.
module prog_sequencer #(
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  output logic [15:0]       reg_enable,
  output logic [3:0]        mux_a,
  output logic [3:0]        mux_b,
  output logic              mux_c,
  output logic [15:0]       alu_control,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   instr_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] PC_LAST = '1;
  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [3:0]        OP_REG  = 4'h0;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic [15:0] reg_en_q, reg_en_d;
  logic [15:0] alu_q, alu_d;
  logic [3:0]  mux_a_q, mux_a_d;
  logic [3:0]  mux_b_q, mux_b_d;
  logic        mux_c_q, mux_c_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        issue;

  // A hold in FETCH or DECODE drops back to FETCH so the ROM word is re-read on release.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = '0;
          count_d = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (!hold) state_d = DECODE;
      end
      DECODE: begin
        if (hold) begin
          state_d = FETCH;
        end else if (imem_data == HALT_WORD) begin
          state_d = DONE;
        end else begin
          ir_d    = imem_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!hold) begin
          count_d = count_q + CNT_ONE;
          if (pc_q == PC_LAST) begin
            state_d = DONE;
          end else begin
            pc_d    = pc_q + PC_ONE;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controls show only on the first EXEC cycle; a held EXEC keeps them low so no double write.
  always_comb begin
    issue    = (state_d == EXEC) && (state_q != EXEC);
    reg_en_d = '0;
    alu_d    = '0;
    mux_a_d  = '0;
    mux_b_d  = '0;
    mux_c_d  = 1'b0;
    if (issue && (ir_d != 16'h0000)) begin
      reg_en_d = 16'h0001 << ir_d[11:8];
      mux_a_d  = ir_d[11:8];
      alu_d    = ir_d;
      if (ir_d[15:12] == OP_REG) begin
        mux_b_d = ir_d[3:0];
      end else begin
        mux_c_d = 1'b1;
      end
    end
    busy_d = (state_d == FETCH) || (state_d == DECODE) || (state_d == EXEC);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      count_q  <= '0;
      reg_en_q <= '0;
      alu_q    <= '0;
      mux_a_q  <= '0;
      mux_b_q  <= '0;
      mux_c_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      count_q  <= count_d;
      reg_en_q <= reg_en_d;
      alu_q    <= alu_d;
      mux_a_q  <= mux_a_d;
      mux_b_q  <= mux_b_d;
      mux_c_q  <= mux_c_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_count = count_q;
  assign reg_enable  = reg_en_q;
  assign alu_control = alu_q;
  assign mux_a       = mux_a_q;
  assign mux_b       = mux_b_q;
  assign mux_c       = mux_c_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: decode vectors, multi-cycle corner cases,
// and randomized programs with random hold/start checked against a program-level model.
module tb_prog_sequencer;

  localparam logic [15:0] HALT = 16'hFFFF;

  logic        clk;
  logic        reset, start, hold;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] reg_enable, alu_control;
  logic [3:0]  mux_a, mux_b;
  logic        mux_c, busy, done;
  logic [8:0]  instr_count;

  logic        reset2, start2, hold2;
  logic [1:0]  imem_addr2;
  logic [15:0] imem_data2;
  logic [15:0] reg_enable2, alu_control2;
  logic [3:0]  mux_a2, mux_b2;
  logic        mux_c2, busy2, done2;
  logic [2:0]  instr_count2;

  logic [15:0] mem  [256];
  logic [15:0] mem2 [4];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] word;
    logic [15:0] reg_en;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        c;
  } vec_t;

  typedef struct {
    logic [15:0] reg_en;
    logic [15:0] alu;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        c;
  } ctrl_t;

  prog_sequencer #(.ADDR_W(8), .HALT_WORD(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .reg_enable(reg_enable), .mux_a(mux_a), .mux_b(mux_b), .mux_c(mux_c),
    .alu_control(alu_control), .busy(busy), .done(done), .instr_count(instr_count)
  );

  prog_sequencer #(.ADDR_W(2), .HALT_WORD(16'hFFFF)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .hold(hold2),
    .imem_addr(imem_addr2), .imem_data(imem_data2),
    .reg_enable(reg_enable2), .mux_a(mux_a2), .mux_b(mux_b2), .mux_c(mux_c2),
    .alu_control(alu_control2), .busy(busy2), .done(done2), .instr_count(instr_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program ROMs: data appears one cycle after the address.
  always @(posedge clk) imem_data  <= mem[imem_addr];
  always @(posedge clk) imem_data2 <= mem2[imem_addr2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic h);
    start = s;
    hold  = h;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = HALT;
  endtask

  task automatic doReset();
    reset = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic ctrl_t expectCtrl(input logic [15:0] w);
    ctrl_t e;
    e.alu    = w;
    e.a      = w[11:8];
    e.reg_en = 16'h0001 << w[11:8];
    if (w[15:12] == 4'h0) begin
      e.b = w[3:0];
      e.c = 1'b0;
    end else begin
      e.b = 4'h0;
      e.c = 1'b1;
    end
    return e;
  endfunction

  task automatic randomRun(input int run_idx);
    ctrl_t       exp_q[$];
    ctrl_t       e;
    logic [15:0] w;
    int          len;
    bit          done_seen;
    clearMem();
    doReset();
    len = $urandom_range(0, 12);
    for (int i = 0; i < len; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) w[15:12] = 4'h0;
      if ($urandom_range(0, 5) == 0) w = 16'h0000;
      if (w == HALT) w = 16'h7E21;
      mem[i] = w;
      if (w != 16'h0000) exp_q.push_back(expectCtrl(w));
    end
    done_seen = 1'b0;
    applyStimulus(1'b1, 1'b0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (reg_enable != 16'h0000 || alu_control != 16'h0000) begin
        if (exp_q.size() == 0) begin
          checkOutput($sformatf("rnd%0d_extra_write", run_idx), {16'h0, alu_control}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("rnd%0d_regen_alu", run_idx), {reg_enable, alu_control}, {e.reg_en, e.alu});
          checkOutput($sformatf("rnd%0d_mux", run_idx), {23'h0, mux_a, mux_b, mux_c}, {23'h0, e.a, e.b, e.c});
        end
      end
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end
    start = 1'b0;
    hold  = 1'b0;
    checkOutput($sformatf("rnd%0d_done_seen", run_idx), 32'(done_seen), 32'd1);
    checkOutput($sformatf("rnd%0d_missing_writes", run_idx), 32'(exp_q.size()), 32'd0);
    checkOutput($sformatf("rnd%0d_count", run_idx), 32'(instr_count), 32'(len));
    checkOutput($sformatf("rnd%0d_final_pc", run_idx), 32'(imem_addr), 32'(len));
    checkOutput($sformatf("rnd%0d_busy_at_done", run_idx), 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    int   done_cycle;
    int   writes;
    bit   flag;

    vecs[0] = '{16'h5103, 16'h0002, 4'h1, 4'h0, 1'b1};
    vecs[1] = '{16'h0251, 16'h0004, 4'h2, 4'h1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 4'h0, 4'h0, 1'b0};
    vecs[3] = '{16'h0F0A, 16'h8000, 4'hF, 4'hA, 1'b0};
    vecs[4] = '{16'hFE07, 16'h4000, 4'hE, 4'h0, 1'b1};
    vecs[5] = '{16'h0001, 16'h0001, 4'h0, 4'h1, 1'b0};
    vecs[6] = '{16'h1000, 16'h0001, 4'h0, 4'h0, 1'b1};

    reset2 = 1'b1;
    start2 = 1'b0;
    hold2  = 1'b0;
    for (int i = 0; i < 4; i++) mem2[i] = 16'h5001;
    clearMem();

    // Reset state.
    doReset();
    checkOutput("reset_ctrl", {reg_enable, alu_control}, 32'h0);
    checkOutput("reset_status", {20'h0, mux_a, mux_b, mux_c, busy, done, 1'b0}, 32'h0);
    checkOutput("reset_pc_count", {15'h0, imem_addr, instr_count}, 32'h0);

    // Single-instruction programs: decode and timing.
    foreach (vecs[v]) begin
      clearMem();
      mem[0] = vecs[v].word;
      doReset();
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      tick();
      checkOutput($sformatf("vec%0d_reg_enable", v), 32'(reg_enable), 32'(vecs[v].reg_en));
      checkOutput($sformatf("vec%0d_alu", v), 32'(alu_control), 32'(vecs[v].word));
      checkOutput($sformatf("vec%0d_mux", v), {23'h0, mux_a, mux_b, mux_c}, {23'h0, vecs[v].a, vecs[v].b, vecs[v].c});
      checkOutput($sformatf("vec%0d_busy_exec", v), 32'(busy), 32'd1);
      tick();
      checkOutput($sformatf("vec%0d_ctrl_after", v), {reg_enable, alu_control}, 32'h0);
      tick();
      tick();
      checkOutput($sformatf("vec%0d_done", v), {30'h0, done, busy}, 32'h2);
      checkOutput($sformatf("vec%0d_count", v), 32'(instr_count), 32'd1);
      tick();
      checkOutput($sformatf("vec%0d_done_pulse", v), 32'(done), 32'd0);
    end

    // Program running to the last address of a 2-bit PC.
    reset2 = 1'b1;
    tick();
    tick();
    reset2 = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    writes = 0;
    done_cycle = -1;
    for (int c = 1; c < 40; c++) begin
      if (reg_enable2 != 16'h0000) writes++;
      if (done2) begin
        done_cycle = c;
        break;
      end
      tick();
    end
    checkOutput("last_addr_execs", 32'(writes), 32'd4);
    checkOutput("last_addr_done_cycle", 32'(done_cycle), 32'd13);
    checkOutput("last_addr_count", 32'(instr_count2), 32'd4);
    tick();
    tick();
    tick();
    checkOutput("last_addr_no_wrap", {24'h0, 6'h0, imem_addr2}, 32'd3);
    checkOutput("last_addr_idle", {31'h0, busy2}, 32'd0);
    reset2 = 1'b1;

    // Hold for five cycles during DECODE of the second instruction.
    clearMem();
    mem[0] = 16'h5103;
    mem[1] = 16'h0123;
    doReset();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    tick();
    tick();
    tick();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hold%0d_ctrl", i), {reg_enable, alu_control}, 32'h0);
      checkOutput($sformatf("hold%0d_addr", i), 32'(imem_addr), 32'd1);
      tick();
    end
    hold = 1'b0;
    checkOutput("hold_count_frozen", 32'(instr_count), 32'd1);
    tick();
    tick();
    checkOutput("hold_exec_regen_alu", {reg_enable, alu_control}, {16'h0002, 16'h0123});
    checkOutput("hold_exec_mux", {23'h0, mux_a, mux_b, mux_c}, {23'h0, 4'h1, 4'h3, 1'b0});
    tick();
    checkOutput("hold_single_exec", {reg_enable, alu_control}, 32'h0);
    tick();
    tick();
    checkOutput("hold_done", 32'(done), 32'd1);
    checkOutput("hold_count", 32'(instr_count), 32'd2);

    // Reset during EXEC of instruction 2 aborts with no done.
    clearMem();
    mem[0] = 16'h5103;
    mem[1] = 16'h0251;
    mem[2] = 16'h0F0A;
    doReset();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("abort_in_exec2", 32'(alu_control), 32'h0251);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort_ctrl", {reg_enable, alu_control}, 32'h0);
    checkOutput("abort_status", {20'h0, mux_a, mux_b, mux_c, busy, done, 1'b0}, 32'h0);
    checkOutput("abort_pc_count", {15'h0, imem_addr, instr_count}, 32'h0);
    flag = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) flag = 1'b1;
      tick();
    end
    checkOutput("abort_no_done", 32'(flag), 32'd0);

    // Start pulses while busy are ignored.
    clearMem();
    mem[0] = 16'h5103;
    mem[1] = 16'h0251;
    doReset();
    done_cycle = -1;
    applyStimulus(1'b1, 1'b0);
    for (int c = 1; c < 40; c++) begin
      if (done) begin
        done_cycle = c;
        break;
      end
      applyStimulus((c == 1 || c == 3 || c == 5), 1'b0);
    end
    start = 1'b0;
    checkOutput("busy_start_done_cycle", 32'(done_cycle), 32'd9);
    checkOutput("busy_start_count", 32'(instr_count), 32'd2);
    tick();
    tick();
    checkOutput("busy_start_idle", 32'(busy), 32'd0);

    // Reset together with start stays IDLE.
    doReset();
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy) flag = 1'b1;
      tick();
    end
    checkOutput("reset_beats_start", 32'(flag), 32'd0);

    // Hold has no effect in IDLE.
    clearMem();
    mem[0] = 16'h5103;
    doReset();
    applyStimulus(1'b1, 1'b1);
    checkOutput("idle_hold_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0);
    tick();
    checkOutput("idle_hold_exec", 32'(alu_control), 32'h5103);

    for (int r = 0; r < 40; r++) randomRun(r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
